qsfp_link_seq: RTL and testbench
================================

Name: qsfp_link_seq

Overview:
- Per-cage QSFP bring-up sequencer; one instance each for the U50 and U32 cages.
- Detects module insertion and debounces ModPrsL, then pulses ResetL and waits for module init.
- Resets the four GT lanes, waits for byte alignment and reports link status.
- Sits between the QSFP pin/GT wrapper signals (resetl, modprsl, lpmode, modsel, soft_reset, gt_txusrrdy/gt_rxusrrdy, rxbyteisaligned) and application_top.

Parameters:
- DEBOUNCE_CYC, 1250000: cycles ModPrsL must stay low before bring-up starts (min 1).
- RESET_CYC, 1250: cycles ResetL is held low (min 1).
- INIT_CYC, 250000000: cycles to wait after ResetL release before touching the GTs (min 1).
- GTRST_CYC, 256: cycles soft_reset is held high (min 1).
- ALIGN_TIMEOUT, 1250000: cycles allowed for alignment before a retry (min 1).
- LANE_MASK, 4'hF: lanes that must align for link_up.

Ports:
- sysclk  in  1  single clock domain.
- resetl  in  1  asynchronous, active-low block reset.
- enable  in  1  1 = allow bring-up; 0 = force ABSENT.
- lpmode_req  in  1  requested LPMode once the module is up.
- modprsl  in  1  ModPrsL pin, asynchronous, low = present.
- rxbyteisaligned  in  4  per-lane alignment, asynchronous (RX domain).
- qsfp_resetl  out  1  module ResetL.
- qsfp_lpmode  out  1  module LPMode.
- qsfp_modsel  out  1  module ModSelL, active low.
- soft_reset  out  4  per-lane GT soft reset.
- gt_txusrrdy  out  4  TX user-ready.
- gt_rxusrrdy  out  4  RX user-ready.
- lane_up  out  4  aligned lanes, valid only in UP.
- link_up  out  1  all LANE_MASK lanes aligned.
- state  out  3  current state encoding.
- retry_count  out  8  saturating GT retry counter.

Behaviour:
- Clock and reset: sysclk is the only clock. resetl is asynchronous and active-low. All flops are in the sysclk domain.
- Synchronisers: modprsl and rxbyteisaligned[3:0] each pass through a 2-flop synchroniser. Only the synchronised copies (prs_s, al_s) are used; input-to-FSM latency is 2 cycles.
- Reset values:
  - state=ABSENT(0), qsfp_resetl=0, qsfp_lpmode=1, qsfp_modsel=1.
  - soft_reset=4'hF, gt_txusrrdy=gt_rxusrrdy=0.
  - lane_up=0, link_up=0, retry_count=0.
  - Synchroniser flops reset to modprsl=1, aligned=0.
- Timer: one 32-bit down-counter, loaded with (N-1) on entry to each timed state. The transition fires on the cycle the counter reads 0, so the state occupies exactly N cycles.
- Global abort: if prs_s=1 or enable=0 in any state, the next state is ABSENT. Abort has priority over every other transition.
- States (registered Moore outputs):
  - ABSENT(0): resetl=0, lpmode=1, modsel=1, soft_reset=F, usrrdy=0, retry_count cleared. Goes to DEBOUNCE when prs_s=0 and enable=1.
  - DEBOUNCE(1): outputs as ABSENT. After DEBOUNCE_CYC cycles, goes to RESET.
  - RESET(2): outputs as ABSENT. After RESET_CYC cycles, goes to INIT_WAIT.
  - INIT_WAIT(3): qsfp_resetl=1, modsel=0, lpmode=1, soft_reset=F. After INIT_CYC cycles, goes to GT_RESET.
  - GT_RESET(4): soft_reset=F, usrrdy=0, lpmode=lpmode_req (registered). After GTRST_CYC cycles, goes to ALIGN_WAIT.
  - ALIGN_WAIT(5): soft_reset=0, gt_txusrrdy=gt_rxusrrdy=4'hF.
    - Goes to UP when (al_s & LANE_MASK)==LANE_MASK.
    - If ALIGN_TIMEOUT cycles elapse first, goes to GT_RESET and retry_count increments.
    - When alignment and timeout expiry occur in the same cycle, UP wins.
  - UP(6): link_up=1, lane_up=al_s&LANE_MASK.
    - If any masked lane drops, goes to GT_RESET next cycle; retry_count increments.
- Outputs in states outside UP: link_up=0 and lane_up=0.
- retry_count saturates at 255 and clears only in ABSENT or on reset.
- LANE_MASK=0: ALIGN_WAIT goes to UP in its first cycle.
- Reset asserted mid-sequence returns all outputs to their reset values immediately, regardless of state.
- State encoding 7 is unreachable; if ever entered, the FSM goes to ABSENT.

Test Plan:
Bench parameters: DEBOUNCE=4, RESET=8, INIT=16, GTRST=8, ALIGN_TIMEOUT=64, LANE_MASK=F; enable=1.
- Insertion: modprsl 1→0 at t0, al=F later → DEBOUNCE at t0+3, qsfp_resetl low 8 cycles, INIT 16, soft_reset high 8, usrrdy=F, link_up=1, state=6.
- Glitch: modprsl low for 3 cycles then high → never leaves DEBOUNCE, returns to ABSENT, qsfp_resetl stays 0.
- Timeout: lane 2 never aligns → GT_RESET after 64 cycles, retry_count=1, repeats to 255 and saturates.
- Link drop in UP: al=F→B → link_up=0 within 3 cycles, state=4, soft_reset=F for 8 cycles, retry_count+1.
- Removal: modprsl→1 while in UP → ABSENT 3 cycles later, qsfp_resetl=0, retry_count=0.
- Async reset asserted in INIT_WAIT → all outputs at reset values in the same cycle; after release, resequences from ABSENT.

Source files
------------

// File: rtl/qsfp_link_seq.sv
// Per-cage QSFP bring-up sequencer.
// Sequence: debounce module presence, pulse ResetL, wait for module init,
// reset the GT lanes, wait for byte alignment, then report link status.
// Any loss of presence or enable returns the sequencer to ABSENT.
module qsfp_link_seq #(
    parameter int unsigned DEBOUNCE_CYC  = 1250000,
    parameter int unsigned RESET_CYC     = 1250,
    parameter int unsigned INIT_CYC      = 250000000,
    parameter int unsigned GTRST_CYC     = 256,
    parameter int unsigned ALIGN_TIMEOUT = 1250000,
    parameter logic [3:0]  LANE_MASK     = 4'hF
) (
    input  logic       sysclk,
    input  logic       resetl,
    input  logic       enable,
    input  logic       lpmode_req,
    input  logic       modprsl,
    input  logic [3:0] rxbyteisaligned,
    output logic       qsfp_resetl,
    output logic       qsfp_lpmode,
    output logic       qsfp_modsel,
    output logic [3:0] soft_reset,
    output logic [3:0] gt_txusrrdy,
    output logic [3:0] gt_rxusrrdy,
    output logic [3:0] lane_up,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_count
);

    typedef enum logic [2:0] {
        ST_ABSENT     = 3'd0,
        ST_DEBOUNCE   = 3'd1,
        ST_RESET      = 3'd2,
        ST_INIT_WAIT  = 3'd3,
        ST_GT_RESET   = 3'd4,
        ST_ALIGN_WAIT = 3'd5,
        ST_UP         = 3'd6
    } state_t;

    // Timer reload values: a state with duration N loads N-1 and exits at 0.
    localparam logic [31:0] DEB_LOAD   = 32'(DEBOUNCE_CYC) - 32'd1;
    localparam logic [31:0] RST_LOAD   = 32'(RESET_CYC) - 32'd1;
    localparam logic [31:0] INIT_LOAD  = 32'(INIT_CYC) - 32'd1;
    localparam logic [31:0] GTRST_LOAD = 32'(GTRST_CYC) - 32'd1;
    localparam logic [31:0] ALIGN_LOAD = 32'(ALIGN_TIMEOUT) - 32'd1;

    // ---------------------------------------------------------------
    // Synchronisers
    // ---------------------------------------------------------------
    logic       prs_meta_reg;
    logic       prs_s;
    logic [3:0] al_meta_reg;
    logic [3:0] al_s;

    // Two-flop synchroniser for ModPrsL; resets to "absent".
    always_ff @(posedge sysclk or negedge resetl) begin
        if (!resetl) begin
            prs_meta_reg <= 1'b1;
            prs_s        <= 1'b1;
        end else begin
            prs_meta_reg <= modprsl;
            prs_s        <= prs_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_al_sync
            // Two-flop synchroniser for one lane's RX alignment flag.
            always_ff @(posedge sysclk or negedge resetl) begin
                if (!resetl) begin
                    al_meta_reg[gi] <= 1'b0;
                    al_s[gi]        <= 1'b0;
                end else begin
                    al_meta_reg[gi] <= rxbyteisaligned[gi];
                    al_s[gi]        <= al_meta_reg[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [31:0] timer_reg, timer_next;
    logic [7:0]  retry_reg, retry_next;
    logic        retry_inc;
    logic        expired;
    logic        aligned;

    logic       qsfp_resetl_reg, qsfp_resetl_next;
    logic       qsfp_lpmode_reg, qsfp_lpmode_next;
    logic       qsfp_modsel_reg, qsfp_modsel_next;
    logic [3:0] soft_reset_reg, soft_reset_next;
    logic [3:0] usrrdy_reg, usrrdy_next;
    logic [3:0] lane_up_reg, lane_up_next;
    logic       link_up_reg, link_up_next;

    assign expired = (timer_reg == 32'd0);
    assign aligned = ((al_s & LANE_MASK) == LANE_MASK);

    // Next-state logic; loss of presence or enable overrides everything.
    always_comb begin
        state_next = state_reg;
        retry_inc  = 1'b0;
        if (prs_s || !enable) begin
            state_next = ST_ABSENT;
        end else begin
            case (state_reg)
                ST_ABSENT:     state_next = ST_DEBOUNCE;
                ST_DEBOUNCE:   if (expired) state_next = ST_RESET;
                ST_RESET:      if (expired) state_next = ST_INIT_WAIT;
                ST_INIT_WAIT:  if (expired) state_next = ST_GT_RESET;
                ST_GT_RESET:   if (expired) state_next = ST_ALIGN_WAIT;
                ST_ALIGN_WAIT: begin
                    // Alignment wins over a simultaneous timeout.
                    if (aligned) begin
                        state_next = ST_UP;
                    end else if (expired) begin
                        state_next = ST_GT_RESET;
                        retry_inc  = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!aligned) begin
                        state_next = ST_GT_RESET;
                        retry_inc  = 1'b1;
                    end
                end
                default:       state_next = ST_ABSENT;
            endcase
        end
    end

    // Timer reload on state entry, otherwise count down to zero.
    always_comb begin
        timer_next = timer_reg;
        if (state_next != state_reg) begin
            case (state_next)
                ST_DEBOUNCE:   timer_next = DEB_LOAD;
                ST_RESET:      timer_next = RST_LOAD;
                ST_INIT_WAIT:  timer_next = INIT_LOAD;
                ST_GT_RESET:   timer_next = GTRST_LOAD;
                ST_ALIGN_WAIT: timer_next = ALIGN_LOAD;
                default:       timer_next = 32'd0;
            endcase
        end else if (!expired) begin
            timer_next = timer_reg - 32'd1;
        end
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        qsfp_resetl_next = 1'b0;
        qsfp_modsel_next = 1'b1;
        qsfp_lpmode_next = 1'b1;
        soft_reset_next  = 4'hF;
        usrrdy_next      = 4'h0;
        lane_up_next     = 4'h0;
        link_up_next     = 1'b0;
        retry_next       = retry_reg;
        case (state_next)
            ST_INIT_WAIT: begin
                qsfp_resetl_next = 1'b1;
                qsfp_modsel_next = 1'b0;
            end
            ST_GT_RESET: begin
                qsfp_resetl_next = 1'b1;
                qsfp_modsel_next = 1'b0;
                qsfp_lpmode_next = lpmode_req;
            end
            ST_ALIGN_WAIT: begin
                qsfp_resetl_next = 1'b1;
                qsfp_modsel_next = 1'b0;
                qsfp_lpmode_next = lpmode_req;
                soft_reset_next  = 4'h0;
                usrrdy_next      = 4'hF;
            end
            ST_UP: begin
                qsfp_resetl_next = 1'b1;
                qsfp_modsel_next = 1'b0;
                qsfp_lpmode_next = lpmode_req;
                soft_reset_next  = 4'h0;
                usrrdy_next      = 4'hF;
                lane_up_next     = al_s & LANE_MASK;
                link_up_next     = 1'b1;
            end
            default: ;
        endcase
        // Retry counter clears only when the module is gone; saturates at 255.
        if (state_next == ST_ABSENT) begin
            retry_next = 8'd0;
        end else if (retry_inc && (retry_reg != 8'hFF)) begin
            retry_next = retry_reg + 8'd1;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge sysclk or negedge resetl) begin
        if (!resetl) begin
            state_reg       <= ST_ABSENT;
            timer_reg       <= 32'd0;
            retry_reg       <= 8'd0;
            qsfp_resetl_reg <= 1'b0;
            qsfp_lpmode_reg <= 1'b1;
            qsfp_modsel_reg <= 1'b1;
            soft_reset_reg  <= 4'hF;
            usrrdy_reg      <= 4'h0;
            lane_up_reg     <= 4'h0;
            link_up_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            retry_reg       <= retry_next;
            qsfp_resetl_reg <= qsfp_resetl_next;
            qsfp_lpmode_reg <= qsfp_lpmode_next;
            qsfp_modsel_reg <= qsfp_modsel_next;
            soft_reset_reg  <= soft_reset_next;
            usrrdy_reg      <= usrrdy_next;
            lane_up_reg     <= lane_up_next;
            link_up_reg     <= link_up_next;
        end
    end

    assign qsfp_resetl = qsfp_resetl_reg;
    assign qsfp_lpmode = qsfp_lpmode_reg;
    assign qsfp_modsel = qsfp_modsel_reg;
    assign soft_reset  = soft_reset_reg;
    assign gt_txusrrdy = usrrdy_reg;
    assign gt_rxusrrdy = usrrdy_reg;
    assign lane_up     = lane_up_reg;
    assign link_up     = link_up_reg;
    assign state       = state_reg;
    assign retry_count = retry_reg;

endmodule

// File: tb/tb_qsfp_link_seq.sv
// Directed testbench for qsfp_link_seq with short timing parameters.
module tb_qsfp_link_seq;

    logic       sysclk;
    logic       resetl;
    logic       enable;
    logic       lpmode_req;
    logic       modprsl;
    logic [3:0] rxbyteisaligned;
    logic       qsfp_resetl;
    logic       qsfp_lpmode;
    logic       qsfp_modsel;
    logic [3:0] soft_reset;
    logic [3:0] gt_txusrrdy;
    logic [3:0] gt_rxusrrdy;
    logic [3:0] lane_up;
    logic       link_up;
    logic [2:0] state;
    logic [7:0] retry_count;

    int checks   = 0;
    int failures = 0;

    qsfp_link_seq #(
        .DEBOUNCE_CYC  (4),
        .RESET_CYC     (8),
        .INIT_CYC      (16),
        .GTRST_CYC     (8),
        .ALIGN_TIMEOUT (64),
        .LANE_MASK     (4'hF)
    ) dut (
        .sysclk          (sysclk),
        .resetl          (resetl),
        .enable          (enable),
        .lpmode_req      (lpmode_req),
        .modprsl         (modprsl),
        .rxbyteisaligned (rxbyteisaligned),
        .qsfp_resetl     (qsfp_resetl),
        .qsfp_lpmode     (qsfp_lpmode),
        .qsfp_modsel     (qsfp_modsel),
        .soft_reset      (soft_reset),
        .gt_txusrrdy     (gt_txusrrdy),
        .gt_rxusrrdy     (gt_rxusrrdy),
        .lane_up         (lane_up),
        .link_up         (link_up),
        .state           (state),
        .retry_count     (retry_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_resetl"}, 32'(qsfp_resetl), 32'd0);
        chk({tag, "_lpmode"}, 32'(qsfp_lpmode), 32'd1);
        chk({tag, "_modsel"}, 32'(qsfp_modsel), 32'd1);
        chk({tag, "_soft"}, 32'(soft_reset), 32'hF);
        chk({tag, "_txrdy"}, 32'(gt_txusrrdy), 32'h0);
        chk({tag, "_rxrdy"}, 32'(gt_rxusrrdy), 32'h0);
        chk({tag, "_laneup"}, 32'(lane_up), 32'h0);
        chk({tag, "_linkup"}, 32'(link_up), 32'd0);
        chk({tag, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    initial begin
        int k;
        resetl          = 1'b0;
        enable          = 1'b1;
        lpmode_req      = 1'b0;
        modprsl         = 1'b1;
        rxbyteisaligned = 4'h0;

        // Reset state
        #12;
        chk_reset_outputs("rst");
        wait_neg(2);
        resetl = 1'b1;
        wait_neg(3);
        chk("idle_state", 32'(state), 32'd0);

        // Glitch: presence low for 3 cycles only
        modprsl = 1'b0;
        wait_neg(3);
        chk("glitch_deb", 32'(state), 32'd1);
        modprsl = 1'b1;
        wait_neg(2);
        chk("glitch_deb2", 32'(state), 32'd1);
        chk("glitch_resetl", 32'(qsfp_resetl), 32'd0);
        wait_neg(1);
        chk("glitch_absent", 32'(state), 32'd0);
        wait_neg(10);
        chk("glitch_stay", 32'(state), 32'd0);
        chk("glitch_resetl2", 32'(qsfp_resetl), 32'd0);

        // Insertion and full bring-up
        modprsl = 1'b0;
        wait_neg(2);
        chk("ins_t2", 32'(state), 32'd0);
        wait_neg(1);
        chk("ins_deb", 32'(state), 32'd1);
        wait_neg(3);
        chk("ins_deb_end", 32'(state), 32'd1);
        wait_neg(1);
        chk("ins_rst", 32'(state), 32'd2);
        chk("ins_rst_resetl", 32'(qsfp_resetl), 32'd0);
        wait_neg(7);
        chk("ins_rst_end", 32'(state), 32'd2);
        chk("ins_rst_resetl2", 32'(qsfp_resetl), 32'd0);
        wait_neg(1);
        chk("ins_init", 32'(state), 32'd3);
        chk("ins_init_resetl", 32'(qsfp_resetl), 32'd1);
        chk("ins_init_modsel", 32'(qsfp_modsel), 32'd0);
        wait_neg(15);
        chk("ins_init_end", 32'(state), 32'd3);
        wait_neg(1);
        chk("ins_gtrst", 32'(state), 32'd4);
        chk("ins_gtrst_soft", 32'(soft_reset), 32'hF);
        chk("ins_gtrst_rdy", 32'(gt_txusrrdy), 32'h0);
        chk("ins_gtrst_lpm", 32'(qsfp_lpmode), 32'd0);
        wait_neg(7);
        chk("ins_gtrst_end", 32'(state), 32'd4);
        chk("ins_gtrst_soft2", 32'(soft_reset), 32'hF);
        wait_neg(1);
        chk("ins_align", 32'(state), 32'd5);
        chk("ins_align_soft", 32'(soft_reset), 32'h0);
        chk("ins_align_txrdy", 32'(gt_txusrrdy), 32'hF);
        chk("ins_align_rxrdy", 32'(gt_rxusrrdy), 32'hF);
        chk("ins_align_link", 32'(link_up), 32'd0);
        rxbyteisaligned = 4'hF;
        wait_neg(2);
        chk("ins_align_sync", 32'(state), 32'd5);
        wait_neg(1);
        chk("ins_up", 32'(state), 32'd6);
        chk("ins_up_link", 32'(link_up), 32'd1);
        chk("ins_up_lanes", 32'(lane_up), 32'hF);
        chk("ins_up_retry", 32'(retry_count), 32'd0);

        // Link drop in UP: lane 2 lost and never returns
        rxbyteisaligned = 4'hB;
        wait_neg(2);
        chk("drop_still_up", 32'(link_up), 32'd1);
        wait_neg(1);
        chk("drop_state", 32'(state), 32'd4);
        chk("drop_link", 32'(link_up), 32'd0);
        chk("drop_lanes", 32'(lane_up), 32'h0);
        chk("drop_soft", 32'(soft_reset), 32'hF);
        chk("drop_retry", 32'(retry_count), 32'd1);
        wait_neg(7);
        chk("drop_gtrst_end", 32'(state), 32'd4);
        wait_neg(1);
        chk("drop_align", 32'(state), 32'd5);

        // Alignment timeout retries up to saturation
        wait_neg(63);
        chk("to_align_end", 32'(state), 32'd5);
        chk("to_retry_pre", 32'(retry_count), 32'd1);
        wait_neg(1);
        chk("to_gtrst", 32'(state), 32'd4);
        chk("to_retry", 32'(retry_count), 32'd2);
        wait_neg(72);
        chk("to_retry3", 32'(retry_count), 32'd3);
        wait_neg(20000);
        chk("sat_retry", 32'(retry_count), 32'd255);
        chk("sat_state", 32'((state == 3'd4) || (state == 3'd5)), 32'd1);
        wait_neg(144);
        chk("sat_hold", 32'(retry_count), 32'd255);

        // Recover alignment (bounded wait for UP)
        rxbyteisaligned = 4'hF;
        k = 0;
        while ((state != 3'd6) && (k < 200)) begin
            wait_neg(1);
            k++;
        end
        chk("recover_up", 32'(state), 32'd6);
        chk("recover_link", 32'(link_up), 32'd1);
        chk("recover_retry", 32'(retry_count), 32'd255);
        lpmode_req = 1'b1;
        wait_neg(1);
        chk("up_lpmode", 32'(qsfp_lpmode), 32'd1);

        // Removal while UP
        modprsl = 1'b1;
        wait_neg(2);
        chk("rem_still_up", 32'(state), 32'd6);
        wait_neg(1);
        chk("rem_state", 32'(state), 32'd0);
        chk("rem_resetl", 32'(qsfp_resetl), 32'd0);
        chk("rem_retry", 32'(retry_count), 32'd0);
        chk("rem_link", 32'(link_up), 32'd0);
        chk("rem_soft", 32'(soft_reset), 32'hF);

        // Async reset asserted in INIT_WAIT
        lpmode_req = 1'b0;
        modprsl = 1'b0;
        wait_neg(20);
        chk("ar_init", 32'(state), 32'd3);
        resetl = 1'b0;
        #1;
        chk_reset_outputs("ar");
        wait_neg(1);
        resetl = 1'b1;
        wait_neg(2);
        chk("ar_absent", 32'(state), 32'd0);
        wait_neg(1);
        chk("ar_deb", 32'(state), 32'd1);
        wait_neg(36);
        chk("ar_align", 32'(state), 32'd5);
        wait_neg(1);
        chk("ar_up", 32'(state), 32'd6);
        chk("ar_up_link", 32'(link_up), 32'd1);

        // Enable low aborts immediately (not synchronised)
        enable = 1'b0;
        wait_neg(1);
        chk("en_abort", 32'(state), 32'd0);
        chk("en_abort_link", 32'(link_up), 32'd0);
        wait_neg(5);
        chk("en_hold", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
